hdmi_clock_ctrl: RTL and testbench
==================================

# hdmi_clock_ctrl

PLL supervisor for the HDMI clocking block. Drives the PLL reset input and monitors the asynchronous PLL lock flag. Releases the downstream video/TMDS reset only after lock has been continuously stable. Retries lock acquisition a bounded number of times and then latches a fault until software or a button requests a restart. Runs on the free-running board oscillator clock, upstream of the PLL, so it keeps running while the PLL is unlocked.

## Interface
- RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (≥1)
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT for lock per attempt (≥1)
- STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before release (≥1)
- MAX_RETRIES, 3: failed attempts tolerated before FAULT (0..15)

- clk_25MHz  in  1  board oscillator clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL LOCK output, asynchronous to `clk_25MHz`
- restart  in  1  synchronous request, sampled high for ≥1 cycle, to restart sequencing
- pll_rst  out  1  active-high reset to the PLL `RST` pin
- video_rst_n  out  1  active-low reset for pixel/TMDS logic
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- retry_cnt  out  4  failed attempts since last RUN or restart
- state  out  3  PLLRST=0, WAIT=1, STABLE=2, RUN=3, FAULT=4

## Operation
- `pll_locked` goes through a 2-flop synchronizer (`lock_s`). No other logic samples `pll_locked`.
- One shared counter `cnt` is cleared on every state entry. Its width is clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES), plus 1.
- All outputs are decoded from registered state. No combinational path from inputs to outputs.
  - `pll_rst` = 1 in PLLRST and FAULT.
  - `video_rst_n` = 1 only in RUN.
- **PLLRST**
  - `cnt` increments each cycle.
  - At `cnt==RST_CYCLES-1` → WAIT.
- **WAIT**
  - `lock_s=1` → STABLE. Lock has priority over timeout on the same cycle.
  - Otherwise, at `cnt==LOCK_TIMEOUT-1` → RETRY.
- **STABLE**
  - `lock_s=0` → RETRY.
  - At `cnt==STABLE_CYCLES-1` with `lock_s=1` → RUN, and `retry_cnt` clears to 0.
- **RUN**
  - `lock_s=0` → RETRY.
- **RETRY** is a decision taken in the same transition, not a separate state:
  - if `retry_cnt==MAX_RETRIES` → FAULT;
  - else `retry_cnt`+1 and → PLLRST.
- **FAULT**
  - Held indefinitely; `retry_cnt` is frozen.
- **restart**
  - `restart=1` in any state → PLLRST with `retry_cnt`=0 and `cnt`=0.
  - `restart` has priority over every other transition.
  - If `restart` is held high, the block stays in PLLRST.
- **Reset**
  - `rst_n` low forces immediately, asynchronously, mid-operation included: state=PLLRST, `cnt`=0, `retry_cnt`=0, both sync flops 0.
  - Reset values: `pll_rst`=1, `video_rst_n`=0, `ready`=0, `fault`=0, `retry_cnt`=0, `state`=0.
- Lock pulses shorter than one clock period may be missed. This is accepted.

## Timing
- After `rst_n` deasserts: `pll_rst` stays high for exactly RST_CYCLES rising edges, then falls (enter WAIT).
- Lock acquisition: let E1 be the first edge that samples `pll_locked=1`.
  - `lock_s`=1 after E1+1.
  - STABLE is entered at E1+2.
  - `video_rst_n`/`ready` rise at E1+STABLE_CYCLES+2, provided lock held throughout.
- Lock loss in RUN: let F1 be the first edge that samples `pll_locked=0`.
  - `video_rst_n`, `ready` fall and `pll_rst` rises at F1+2.
- WAIT lasts exactly LOCK_TIMEOUT cycles when no lock arrives.
- Full failed attempt = RST_CYCLES + LOCK_TIMEOUT cycles.
- `restart` sampled at edge R: outputs reflect PLLRST after R.

## Test plan
Unless noted, params are RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.

1. **Nominal lock.** Release `rst_n`; raise `pll_locked` 10 cycles after `pll_rst` falls → `pll_rst` high exactly 4 cycles; `video_rst_n`=`ready`=1 exactly 10 edges after the first sampling edge; `retry_cnt`=0; `state`=3.
2. **No lock.** Hold `pll_locked`=0 → three attempts of 36 cycles; `retry_cnt` reads 1 then 2; FAULT at cycle 108; `fault`=1, `pll_rst`=1, `state`=4 held for ≥200 cycles.
3. **Bounce in STABLE.** Lock for 5 cycles, drop for 2 cycles, then hold → STABLE→PLLRST with `retry_cnt`=1; second attempt reaches RUN with `retry_cnt`=0.
4. **Loss in RUN.** From RUN, drop `pll_locked` → `video_rst_n` low and `pll_rst` high at F1+2; `retry_cnt`=1; relock returns to RUN.
5. **restart.** Pulse `restart` in FAULT and separately in RUN → next cycle `state`=0, `retry_cnt`=0, `fault`=0, `video_rst_n`=0; nominal sequence resumes.
6. **Async reset mid-STABLE.** Assert `rst_n` low between clock edges mid-STABLE → all outputs at reset values before the next edge; after release, a full PLLRST of 4 cycles is observed.

Source files
------------

// File: rtl/hdmi_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_clock_ctrl
// Description : PLL supervisor for the HDMI clocking block. Holds the PLL in
//               reset, waits for a synchronized lock, requires the lock to be
//               stable before releasing the video/TMDS reset, retries a bounded
//               number of times and then latches a fault until restarted.
//               Runs on the free-running board oscillator, upstream of the PLL.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_clock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       video_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    // One shared phase counter sized for the longest of the three intervals
    localparam int c_MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_CNT_MAX = (c_MAX_A > STABLE_CYCLES) ? c_MAX_A : STABLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_RST_LAST     = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO     = '0;
    localparam logic [3:0]         c_RETRY_LIMIT  = 4'(MAX_RETRIES);

    // State encoding is visible on the state output, so it is fixed here
    localparam logic [2:0] c_ST_PLLRST = 3'd0;
    localparam logic [2:0] c_ST_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_STABLE = 3'd2;
    localparam logic [2:0] c_ST_RUN    = 3'd3;
    localparam logic [2:0] c_ST_FAULT  = 3'd4;

    logic               r_lock_meta;
    logic               r_lock_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_retry_cnt;
    logic               w_retry_exhausted;

    assign w_retry_exhausted = (r_retry_cnt == c_RETRY_LIMIT);

    // Two-flop synchronizer: the only place pll_locked is sampled
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Sequencer: restart wins over everything, a failed attempt either
    // re-enters PLLRST with one more retry counted or latches FAULT
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_PLLRST;
            r_cnt       <= c_CNT_ZERO;
            r_retry_cnt <= 4'd0;
        end else if (restart) begin
            r_state     <= c_ST_PLLRST;
            r_cnt       <= c_CNT_ZERO;
            r_retry_cnt <= 4'd0;
        end else begin
            case (r_state)
                c_ST_PLLRST: begin
                    if (r_cnt == c_RST_LAST) begin
                        r_state <= c_ST_WAIT;
                        r_cnt   <= c_CNT_ZERO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (r_lock_s) begin
                        r_state <= c_ST_STABLE;
                        r_cnt   <= c_CNT_ZERO;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_cnt <= c_CNT_ZERO;
                        if (w_retry_exhausted) begin
                            r_state <= c_ST_FAULT;
                        end else begin
                            r_state     <= c_ST_PLLRST;
                            r_retry_cnt <= r_retry_cnt + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_STABLE: begin
                    if (!r_lock_s) begin
                        r_cnt <= c_CNT_ZERO;
                        if (w_retry_exhausted) begin
                            r_state <= c_ST_FAULT;
                        end else begin
                            r_state     <= c_ST_PLLRST;
                            r_retry_cnt <= r_retry_cnt + 4'd1;
                        end
                    end else if (r_cnt == c_STABLE_LAST) begin
                        r_state     <= c_ST_RUN;
                        r_cnt       <= c_CNT_ZERO;
                        r_retry_cnt <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RUN: begin
                    // Counter is idle here so it cannot wrap during long runs
                    if (!r_lock_s) begin
                        r_cnt <= c_CNT_ZERO;
                        if (w_retry_exhausted) begin
                            r_state <= c_ST_FAULT;
                        end else begin
                            r_state     <= c_ST_PLLRST;
                            r_retry_cnt <= r_retry_cnt + 4'd1;
                        end
                    end
                end
                c_ST_FAULT: begin
                    // Latched until restart or rst_n; retry count frozen
                    r_state <= c_ST_FAULT;
                end
                default: begin
                    r_state <= c_ST_PLLRST;
                    r_cnt   <= c_CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs depend only on registered state
    assign pll_rst     = (r_state == c_ST_PLLRST) || (r_state == c_ST_FAULT);
    assign video_rst_n = (r_state == c_ST_RUN);
    assign ready       = (r_state == c_ST_RUN);
    assign fault       = (r_state == c_ST_FAULT);
    assign retry_cnt   = r_retry_cnt;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_clock_ctrl
// Description : Self-checking bench for hdmi_clock_ctrl. A phase/elapsed-time
//               reference model predicts all outputs every cycle; directed
//               steps measure the key latencies, then random lock/restart/
//               reset activity is applied.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_clock_ctrl;

    localparam int RST_C = 4;
    localparam int TO_C  = 32;
    localparam int STB_C = 8;
    localparam int MAXR  = 2;

    logic       clk_25MHz = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       video_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    // Reference model: phase (0..4 as on the state output), attempts used,
    // cycles spent in the phase, and the history of sampled lock values
    int       m_phase;
    int       m_tries;
    int       m_age;
    bit [2:0] m_hist;

    hdmi_clock_ctrl #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TO_C),
        .STABLE_CYCLES(STB_C),
        .MAX_RETRIES  (MAXR)
    ) u_dut (
        .clk_25MHz  (clk_25MHz),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .video_rst_n(video_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    always #5 clk_25MHz = ~clk_25MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_phase = 0;
        m_tries = 0;
        m_age   = 0;
        m_hist  = 3'b000;
    endfunction

    function automatic void m_enter(input int p);
        m_phase = p;
        m_age   = 0;
    endfunction

    function automatic void m_fail();
        if (m_tries == MAXR) m_enter(4);
        else begin
            m_tries++;
            m_enter(0);
        end
    endfunction

    // Decisions at an edge use the lock level sampled two edges earlier
    function automatic void model_edge();
        bit lk;
        if (!rst_n) begin
            m_reset();
            return;
        end
        m_hist = {m_hist[1:0], pll_locked === 1'b1};
        lk     = m_hist[2];
        if (restart) begin
            m_tries = 0;
            m_enter(0);
        end else begin
            case (m_phase)
                0: if (m_age + 1 == RST_C) m_enter(1); else m_age++;
                1: if (lk) m_enter(2); else if (m_age + 1 == TO_C) m_fail(); else m_age++;
                2: if (!lk) m_fail();
                   else if (m_age + 1 == STB_C) begin m_enter(3); m_tries = 0; end
                   else m_age++;
                3: if (!lk) m_fail();
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] expv();
        bit pr;
        pr = (m_phase == 0) || (m_phase == 4);
        return {21'b0, 3'(m_phase), 4'(m_tries), pr, m_phase == 3, m_phase == 3, m_phase == 4};
    endfunction

    function automatic logic [31:0] obsv();
        return {21'b0, state, retry_cnt, pll_rst, video_rst_n, ready, fault};
    endfunction

    task automatic tick();
        @(posedge clk_25MHz);
        model_edge();
        #1;
        chk("cycle_outputs", obsv(), expv());
    endtask

    initial begin
        int n;
        int r;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        m_reset();

        // Reset held across edges
        repeat (3) tick();
        #3 rst_n = 1'b1;

        // Nominal lock: pll_rst length and lock-to-ready latency
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick(); n++;
            if (pll_rst === 1'b0) break;
        end
        chk("t1_pllrst_len", n, RST_C);
        repeat (10) tick();
        pll_locked = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick(); n++;
            if (ready === 1'b1) break;
        end
        chk("t1_ready_latency", n, STB_C + 3);
        chk("t1_state", state, 3);
        chk("t1_retry", retry_cnt, 0);

        // Loss in RUN: pll_rst rises at F1+2, then relock
        repeat (5) tick();
        pll_locked = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick(); n++;
            if (pll_rst === 1'b1) break;
        end
        chk("t4_loss_latency", n, 3);
        chk("t4_retry", retry_cnt, 1);
        chk("t4_video_rst_n", video_rst_n, 0);
        pll_locked = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (ready === 1'b1) break;
        end
        chk("t4_relock_state", state, 3);
        chk("t4_relock_retry", retry_cnt, 0);

        // restart in RUN
        restart = 1'b1; tick(); restart = 1'b0;
        chk("t5_run_restart", {state, retry_cnt, fault, video_rst_n}, {3'd0, 4'd0, 1'b0, 1'b0});
        for (int k = 0; k < 200; k++) begin
            tick();
            if (ready === 1'b1) break;
        end
        chk("t5_run_resume", state, 3);

        // No lock: three full attempts then FAULT, held
        pll_locked = 1'b0;
        restart = 1'b1; tick(); restart = 1'b0;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            tick(); n++;
            if (fault === 1'b1) break;
        end
        chk("t2_fault_time", n, (MAXR + 1) * (RST_C + TO_C));
        repeat (200) tick();
        chk("t2_fault_hold", {fault, pll_rst, state, retry_cnt}, {1'b1, 1'b1, 3'd4, 4'(MAXR)});

        // restart in FAULT
        pll_locked = 1'b1;
        restart = 1'b1; tick(); restart = 1'b0;
        chk("t5_fault_restart", {state, retry_cnt, fault, video_rst_n}, {3'd0, 4'd0, 1'b0, 1'b0});
        for (int k = 0; k < 200; k++) begin
            tick();
            if (ready === 1'b1) break;
        end
        chk("t5_fault_resume", state, 3);

        // Bounce in STABLE
        pll_locked = 1'b0;
        restart = 1'b1; tick(); restart = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (pll_rst === 1'b0) break;
        end
        pll_locked = 1'b1; repeat (5) tick();
        pll_locked = 1'b0; repeat (2) tick();
        pll_locked = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (pll_rst === 1'b1) break;
        end
        chk("t3_bounce", {state, retry_cnt}, {3'd0, 4'd1});
        for (int k = 0; k < 200; k++) begin
            tick();
            if (ready === 1'b1) break;
        end
        chk("t3_recover", {state, retry_cnt}, {3'd3, 4'd0});

        // Async reset mid-STABLE
        pll_locked = 1'b0;
        restart = 1'b1; tick(); restart = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (pll_rst === 1'b0) break;
        end
        pll_locked = 1'b1;
        repeat (5) tick();
        chk("t6_in_stable", state, 2);
        #2 rst_n = 1'b0;
        #1 m_reset();
        chk("t6_async_reset", obsv(), expv());
        tick();
        #3 rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick(); n++;
            if (pll_rst === 1'b0) break;
        end
        chk("t6_pllrst_len", n, RST_C);

        // Random lock activity, restarts and resets against the model
        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
                restart = 1'b1; tick(); restart = 1'b0;
            end else if (r == 1) begin
                #2 rst_n = 1'b0;
                #1 m_reset();
                chk("rnd_async_reset", obsv(), expv());
                tick();
                #3 rst_n = 1'b1;
            end else begin
                pll_locked = ($urandom_range(0, 3) != 0);
                repeat (int'($urandom_range(1, 40))) tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
